// File: rtl/sumsq_arbiter.sv
// Round-robin scheduler sharing one square-and-accumulate pipeline among NREQ streams.
// Each stream keeps its own accumulator and sticky overflow flag, and a tagged result is emitted on its last sample.
module sumsq_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 20,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDW-1:0]     out_id,
    output logic [AW-1:0]      out_data,
    output logic               out_ovf
);

    logic [IDW-1:0]  ptr;
    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    logic [DW-1:0]   s1_data;
    logic            s1_last;
    logic [AW-1:0]   acc [NREQ];
    logic [NREQ-1:0] ovf;

    logic            stall;
    logic            accept;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] grant;
    logic [DW-1:0]   grant_data;
    logic            grant_last;
    logic            s2_run;
    logic            result_load;
    logic [2*DW-1:0] s1_data_ext;
    logic [2*DW-1:0] square;
    logic [AW:0]     sum;

    // First requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        logic [IDW-1:0] cand;
        grant      = '0;
        grant_any  = 1'b0;
        grant_id   = '0;
        base       = 32'(ptr);
        idx        = 0;
        cand       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx  = (base + k) % NREQ;
            cand = IDW'(idx);
            if (!grant_any && req_valid[cand]) begin
                grant_any   = 1'b1;
                grant_id    = cand;
                grant[cand] = 1'b1;
            end
        end
        grant_data = req_data[grant_id*DW +: DW];
        grant_last = req_last[grant_id];
    end

    assign stall       = s1_valid && s1_last && out_valid && !out_ready;
    assign accept      = grant_any && !stall && !reset;
    assign req_ready   = grant & {NREQ{!stall && !reset}};
    assign s2_run      = s1_valid && !stall;
    assign result_load = s2_run && s1_last;

    assign s1_data_ext = {{DW{1'b0}}, s1_data};
    assign square      = s1_data_ext * s1_data_ext;
    // Bit AW of the sum is the wrap indicator for this accumulation step.
    assign sum         = {1'b0, acc[s1_id]} + {{(AW+1-2*DW){1'b0}}, square};

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_data   <= '0;
            s1_last   <= 1'b0;
            ovf       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (accept) begin
                ptr      <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                s1_valid <= 1'b1;
                s1_id    <= grant_id;
                s1_data  <= grant_data;
                s1_last  <= grant_last;
            end else if (!stall) begin
                s1_valid <= 1'b0;
            end

            if (s2_run) begin
                if (!s1_last) begin
                    acc[s1_id] <= sum[AW-1:0];
                    ovf[s1_id] <= ovf[s1_id] | sum[AW];
                end else begin
                    out_data   <= sum[AW-1:0];
                    out_id     <= s1_id;
                    out_ovf    <= ovf[s1_id] | sum[AW];
                    acc[s1_id] <= '0;
                    ovf[s1_id] <= 1'b0;
                end
            end

            if (result_load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sumsq_arbiter.sv
// Self-checking bench for sumsq_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_sumsq_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int IDW  = 2;
    localparam longint WRAP = 64'd1 << AW;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [IDW-1:0]     out_id;
    logic [AW-1:0]      out_data;
    logic               out_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sumsq_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        r;
        logic [3:0]  er;
        logic        ev;
        int          id;
        int          data;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input int id, input longint data,
                           input logic eovf);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        if (ev) begin
            chk({tag, ".out_id"}, 64'(out_id), 64'(id));
            chk({tag, ".out_data"}, 64'(out_data), 64'(data));
            chk({tag, ".out_ovf"}, 64'(out_ovf), 64'(eovf));
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                         input logic r);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_id", 64'(out_id), 64'd0);
        chk("rst.out_data", 64'(out_data), 64'd0);
        chk("rst.out_ovf", 64'(out_ovf), 64'd0);
    endtask

    // Reference model: pending S1 slot, one result register, unbounded true per-stream totals.
    int          m_ptr;
    bit          m_s1v;
    bit          m_s1l;
    int          m_s1id;
    longint      m_s1d;
    longint      m_tot [NREQ];
    bit          m_ov;
    int          m_oid;
    longint      m_odata;
    bit          m_oovf;

    initial begin
        vec_t tbl[13];
        int   rr_exp[12];
        logic [3:0]  rv;
        logic [31:0] rd;
        logic [3:0]  rl;
        logic        rr;
        logic [3:0]  exp_rdy;
        bit          m_stall;
        bit          loaded;
        int          g;
        int          ci;

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;

        tbl = '{
            '{4'h1, 32'h00000001, 4'h0, 1, 4'h1, 0, 0, 0, 0},
            '{4'h1, 32'h00000002, 4'h0, 1, 4'h1, 0, 0, 0, 0},
            '{4'h1, 32'h00000003, 4'h1, 1, 4'h1, 0, 0, 0, 0},
            '{4'h0, 32'h00000000, 4'h0, 1, 4'h0, 0, 0, 0, 0},
            '{4'h0, 32'h00000000, 4'h0, 1, 4'h0, 1, 0, 14, 0},
            '{4'h0, 32'h00000000, 4'h0, 1, 4'h0, 0, 0, 0, 0},
            '{4'h6, 32'h00050A00, 4'h0, 1, 4'h2, 0, 0, 0, 0},
            '{4'h6, 32'h00051400, 4'h2, 1, 4'h4, 0, 0, 0, 0},
            '{4'h6, 32'h00051400, 4'h6, 1, 4'h2, 0, 0, 0, 0},
            '{4'h4, 32'h00050000, 4'h4, 1, 4'h4, 0, 0, 0, 0},
            '{4'h0, 32'h00000000, 4'h0, 1, 4'h0, 1, 1, 500, 0},
            '{4'h0, 32'h00000000, 4'h0, 1, 4'h0, 1, 2, 50, 0},
            '{4'h0, 32'h00000000, 4'h0, 1, 4'h0, 0, 0, 0, 0}
        };
        rr_exp = '{1, 2, 4, 8, 1, 2, 4, 8, 1, 2, 8, 1};

        // Single stream followed by two interleaved streams.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk($sformatf("vec%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].er));
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].id, longint'(tbl[i].data), tbl[i].ovf);
            tick();
        end

        // Round robin with all requesting, then stream 2 drops out.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive((c < 8) ? 4'hF : 4'hB, 32'h01010101, 4'h0, 1'b1);
            chk($sformatf("rr%0d.req_ready", c), 64'(req_ready), 64'(rr_exp[c]));
            tick();
        end

        // Backpressure: two single-sample results with the consumer stalled.
        do_reset();
        drive(4'h3, 32'h00000403, 4'h3, 1'b0);
        chk("bp0.req_ready", 64'(req_ready), 64'd1);
        tick();
        drive(4'h2, 32'h00000400, 4'h2, 1'b0);
        chk("bp1.req_ready", 64'(req_ready), 64'd2);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(4'h4, 32'h00070000, 4'h0, 1'b0);
            chk($sformatf("bp_stall%0d.req_ready", c), 64'(req_ready), 64'd0);
            chk_out($sformatf("bp_stall%0d", c), 1'b1, 0, 64'd9, 1'b0);
            tick();
        end
        drive(4'h4, 32'h00070000, 4'h0, 1'b1);
        chk("bp_release.req_ready", 64'(req_ready), 64'd4);
        chk_out("bp_release", 1'b1, 0, 64'd9, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(4'h0, 32'h0, 4'h0, 1'b0);
            chk_out($sformatf("bp_second%0d", c), 1'b1, 1, 64'd16, 1'b0);
            tick();
        end
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        chk_out("bp_last_hold", 1'b1, 1, 64'd16, 1'b0);
        tick();
        chk_out("bp_drained", 1'b0, 0, 64'd0, 1'b0);

        // Overflow: seventeen 255s on stream 3, then a fresh one-sample run.
        for (int j = 0; j < 17; j++) begin
            drive(4'h8, 32'hFF000000, (j == 16) ? 4'h8 : 4'h0, 1'b1);
            chk($sformatf("ovf%0d.req_ready", j), 64'(req_ready), 64'd8);
            tick();
        end
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        chk_out("ovf_wait", 1'b0, 0, 64'd0, 1'b0);
        tick();
        chk_out("ovf_result", 1'b1, 3, 64'd56849, 1'b1);
        drive(4'h8, 32'h02000000, 4'h8, 1'b1);
        chk("ovf_small.req_ready", 64'(req_ready), 64'd8);
        tick();
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        chk_out("ovf_small_wait", 1'b0, 0, 64'd0, 1'b0);
        tick();
        chk_out("ovf_small", 1'b1, 3, 64'd4, 1'b0);
        tick();

        // Reset in the middle of a stream-0 run discards the partial sum.
        drive(4'h1, 32'h00000064, 4'h0, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        drive(4'hF, 32'h03030303, 4'h0, 1'b1);
        chk("mid_rst.req_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b0;
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst.out_id", 64'(out_id), 64'd0);
        chk("mid_rst.out_data", 64'(out_data), 64'd0);
        chk("mid_rst.out_ovf", 64'(out_ovf), 64'd0);
        drive(4'h3, 32'h00000103, 4'h1, 1'b1);
        chk("mid_rst.ptr0", 64'(req_ready), 64'd1);
        req_valid = 4'h1;
        tick();
        drive(4'h0, 32'h0, 4'h0, 1'b1);
        chk_out("mid_rst_wait", 1'b0, 0, 64'd0, 1'b0);
        tick();
        chk_out("mid_rst_result", 1'b1, 0, 64'd9, 1'b0);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        m_ptr = 0;
        m_s1v = 0;
        m_s1l = 0;
        m_s1id = 0;
        m_s1d = 0;
        m_ov = 0;
        m_oid = 0;
        m_odata = 0;
        m_oovf = 0;
        for (int i = 0; i < NREQ; i++) m_tot[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            rv = 4'($urandom);
            rd = ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFF : $urandom;
            rl = 4'($urandom & $urandom & $urandom & $urandom);
            rr = ($urandom_range(0, 3) != 0);
            drive(rv, rd, rl, rr);

            m_stall = m_s1v && m_s1l && m_ov && !rr;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                ci = (m_ptr + k) % NREQ;
                if (g < 0 && rv[ci]) g = ci;
            end
            exp_rdy = (g >= 0 && !m_stall) ? 4'(1 << g) : 4'h0;
            chk("rnd.req_ready", 64'(req_ready), 64'(exp_rdy));
            chk_out("rnd", m_ov, m_oid, m_odata, m_oovf);
            tick();

            loaded = 0;
            if (m_s1v && !m_stall) begin
                m_tot[m_s1id] += m_s1d * m_s1d;
                if (m_s1l) begin
                    m_oid   = m_s1id;
                    m_odata = m_tot[m_s1id] % WRAP;
                    m_oovf  = (m_tot[m_s1id] >= WRAP);
                    m_ov    = 1;
                    m_tot[m_s1id] = 0;
                    loaded  = 1;
                end
            end
            if (!loaded && m_ov && rr) m_ov = 0;
            if (exp_rdy != 4'h0) begin
                m_s1v  = 1;
                m_s1id = g;
                m_s1d  = longint'(rd[g*DW +: DW]);
                m_s1l  = rl[g];
                m_ptr  = (g + 1) % NREQ;
            end else if (!m_stall) begin
                m_s1v = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sumsq_arbiter.md
# sumsq_arbiter

Round-robin scheduler that shares one sum-of-squares datapath among NREQ independent sample streams. Each stream has its own 20-bit accumulator context. The block arbitrates accepted samples into a single square-and-accumulate pipeline and emits a tagged result when a stream marks its last sample. It sits between the stream producers and the downstream result consumer, replacing per-stream accumulator instances.

## Interface
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ)
- DW, 8, sample width
- AW, 20, accumulator/result width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  reset, synchronous, active-high; clock clk
- req_valid  input  NREQ  per-stream sample valid
- req_data  input  NREQ*DW  per-stream sample, stream i at bits [i*DW +: DW], unsigned
- req_last  input  NREQ  per-stream last-sample flag, qualified by req_valid
- req_ready  output  NREQ  per-stream accept, at most one bit high
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_id  output  IDW  stream index of result
- out_data  output  AW  accumulated sum of squares
- out_ovf  output  1  sum wrapped past 2^AW for this result

## Operation
- Arbiter: grant goes to the first i with req_valid[i], searching from pointer ptr upward, modulo NREQ. req_ready[i] = grant[i] && !stall. Combinational; req_ready may depend on req_valid.
- Accept: req_valid[i] && req_ready[i]. On accept, ptr <= (i+1) mod NREQ. ptr is unchanged otherwise.
- Stage S1 register holds s1_valid, s1_id, s1_data, s1_last. It loads on accept. It clears when there is no accept and no stall.
- Stage S2 (accumulate) runs when s1_valid && !stall:
  - sum = acc[s1_id] + s1_data*s1_data, computed at AW+1 bits.
  - If !s1_last: acc[s1_id] <= sum[AW-1:0], and ovf[s1_id] |= sum[AW].
  - If s1_last: out_data <= sum[AW-1:0], out_id <= s1_id, out_ovf <= ovf[s1_id] | sum[AW], out_valid <= 1. Then acc[s1_id] <= 0 and ovf[s1_id] <= 0.
- Output: when out_valid && out_ready and no new result is loaded that cycle, out_valid <= 0. Otherwise out_valid holds. A new result may load in the same cycle the old one is consumed.
- stall = s1_valid && s1_last && out_valid && !out_ready. While stalled:
  - S1 holds.
  - All req_ready are 0.
  - No accumulator changes.
- Non-last samples never stall.
- Arithmetic: unsigned throughout. The square is 2*DW bits, zero-extended to AW+1. Accumulation wraps modulo 2^AW, and the per-stream ovf flag is sticky until that stream's last sample.
- A single-sample stream (req_last on its first sample) gives out_data = data^2.
- Back-to-back samples of the same stream are legal every cycle. S2 reads acc in the same cycle it writes it, so there is no hazard.
- Reset, including mid-stream:
  - ptr=0, s1_valid=0, all acc=0, all ovf=0.
  - out_valid=0, out_id=0, out_data=0, out_ovf=0.
  - req_ready is held at 0 during the reset cycle.
  - In-flight partial sums are discarded.

## Timing
- Sample accepted at edge k → accumulated at edge k+1.
- Last sample accepted at edge k → out_valid high after edge k+1, so latency is 2 cycles. Extra latency comes only from stall.
- Throughput: one accepted sample per cycle across all streams while not stalled.
- Fairness: with all NREQ requesting continuously, grants go i, i+1, …; each stream is served once every NREQ cycles.
- A held result persists until out_ready. Its out_id, out_data and out_ovf stay stable while out_valid && !out_ready.

## Test plan
- Single stream: stream 0 sends 1, 2, 3 (last) on consecutive cycles with out_ready=1. Expect out_valid 2 cycles after the last accept, out_id=0, out_data=14, out_ovf=0, then out_valid drops.
- Round robin: all 4 streams request continuously from reset. Expect the grant order 0,1,2,3,0,… with exactly one req_ready high per cycle. A stream dropping req_valid is skipped with no idle cycle.
- Interleave: stream 1 sends 10, 20 and stream 2 sends 5, 5 (last on each second sample), interleaved by the arbiter. Expect results id=1 data=500 and id=2 data=50, in grant order of their last samples.
- Backpressure: two streams each send a single last sample, with out_ready=0. Expect:
  - the first result is held stable;
  - the second is held in S1;
  - req_ready stays all-0 while stalled;
  - raising out_ready for one cycle delivers the second result the next cycle with no loss.
- Overflow: stream 3 sends 17 samples of 255, the last flagged. Expect out_data=56849 and out_ovf=1. A following 1-sample stream-3 run of 2 gives out_data=4, out_ovf=0.
- Reset mid-operation: stream 0 sends 100, 100, then reset for 1 cycle, then 3 (last). Expect out_data=9. All outputs are 0 during and right after reset, and ptr restarts at 0.
